// File: rtl/regfile_wb_queue.sv
// Register-file writeback queue: buffers writes behind a stallable RegFile port
// and forwards pending (not yet written) values to the two read queries.
module regfile_wb_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_data,
  input  logic        wr_stall,
  output logic [4:0]  W_write_rd,
  output logic [31:0] W_write_data,
  output logic        W_en,
  input  logic [4:0]  query_rs,
  input  logic [4:0]  query_rt,
  output logic        rs_hit,
  output logic        rt_hit,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  output logic [3:0]  count
);

  localparam int PW = $clog2(DEPTH);

  logic [4:0]    rd_mem   [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [PW-1:0] head_reg;
  logic [PW-1:0] tail_reg;
  logic [3:0]    count_reg;
  logic [4:0]    w_rd_reg;
  logic [31:0]   w_data_reg;
  logic          w_en_reg;

  logic push;
  logic pop;

  assign in_ready = (count_reg < 4'(DEPTH));
  // Writes to r0 are accepted but dropped; they never occupy a slot.
  assign push     = in_valid & in_ready & (in_rd != 5'd0);
  assign pop      = (count_reg != 4'd0) & ~wr_stall;

  assign count        = count_reg;
  assign W_en         = w_en_reg;
  assign W_write_rd   = w_rd_reg;
  assign W_write_data = w_data_reg;

  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[tail_reg]   <= in_rd;
      data_mem[tail_reg] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_reg   <= '0;
      tail_reg   <= '0;
      count_reg  <= '0;
      w_en_reg   <= 1'b0;
      w_rd_reg   <= '0;
      w_data_reg <= '0;
    end else begin
      w_en_reg <= pop;
      if (push) begin
        tail_reg <= tail_reg + 1'b1;
      end
      if (pop) begin
        head_reg   <= head_reg + 1'b1;
        w_rd_reg   <= rd_mem[head_reg];
        w_data_reg <= data_mem[head_reg];
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 4'd1;
        2'b01:   count_reg <= count_reg - 4'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Queue contents reordered by age: slot 0 is the head (oldest), higher slots are younger.
  logic [DEPTH-1:0] slot_live;
  logic [4:0]       slot_rd   [DEPTH];
  logic [31:0]      slot_data [DEPTH];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      wire [PW-1:0] idx = head_reg + PW'(gi);
      assign slot_live[gi] = (4'(gi) < count_reg);
      assign slot_rd[gi]   = rd_mem[idx];
      assign slot_data[gi] = data_mem[idx];
    end
  endgenerate

  // Scan oldest to youngest so the last match wins.
  always_comb begin
    rs_hit  = 1'b0;
    rs_data = '0;
    if (query_rs != 5'd0) begin
      if (w_en_reg && (w_rd_reg == query_rs)) begin
        rs_hit  = 1'b1;
        rs_data = w_data_reg;
      end
      for (int k = 0; k < DEPTH; k++) begin
        if (slot_live[k] && (slot_rd[k] == query_rs)) begin
          rs_hit  = 1'b1;
          rs_data = slot_data[k];
        end
      end
    end
  end

  always_comb begin
    rt_hit  = 1'b0;
    rt_data = '0;
    if (query_rt != 5'd0) begin
      if (w_en_reg && (w_rd_reg == query_rt)) begin
        rt_hit  = 1'b1;
        rt_data = w_data_reg;
      end
      for (int k = 0; k < DEPTH; k++) begin
        if (slot_live[k] && (slot_rd[k] == query_rt)) begin
          rt_hit  = 1'b1;
          rt_data = slot_data[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Self-checking bench for regfile_wb_queue: scenario tasks plus a writeback
// scoreboard that checks every W_en pulse against the accepted request order.
module tb_regfile_wb_queue;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [31:0] in_data;
  logic        wr_stall;
  logic [4:0]  W_write_rd;
  logic [31:0] W_write_data;
  logic        W_en;
  logic [4:0]  query_rs;
  logic [4:0]  query_rt;
  logic        rs_hit;
  logic        rt_hit;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [3:0]  count;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t sb[$];
  ent_t mon_exp;
  int   vectors;
  int   miscompares;

  regfile_wb_queue #(.DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_rd        (in_rd),
    .in_data      (in_data),
    .wr_stall     (wr_stall),
    .W_write_rd   (W_write_rd),
    .W_write_data (W_write_data),
    .W_en         (W_en),
    .query_rs     (query_rs),
    .query_rt     (query_rt),
    .rs_hit       (rs_hit),
    .rt_hit       (rt_hit),
    .rs_data      (rs_data),
    .rt_data      (rt_data),
    .count        (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every W_en pulse must match the oldest accepted, unwritten request.
  always @(negedge clk) begin
    if (W_en === 1'b1) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL wb_unexpected: got rd=%0d data=%h, required no W_en pulse", W_write_rd, W_write_data);
      end else begin
        mon_exp = sb.pop_front();
        if ({W_write_rd, W_write_data} !== {mon_exp.rd, mon_exp.data}) begin
          miscompares++;
          $display("FAIL wb_order: got rd=%0d data=%h, required rd=%0d data=%h",
                   W_write_rd, W_write_data, mon_exp.rd, mon_exp.data);
        end else begin
          $display("wb rd=%0d data=%h", W_write_rd, W_write_data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Forwarding reference: pending writes are exactly the scoreboard contents; youngest wins.
  function automatic void model_fwd(input logic [4:0] q, output logic hit, output logic [31:0] d);
    hit = 1'b0;
    d   = '0;
    if (q != 5'd0) begin
      for (int j = 0; j < sb.size(); j++) begin
        if (sb[j].rd == q) begin
          hit = 1'b1;
          d   = sb[j].data;
        end
      end
    end
  endfunction

  // Called #1 after a posedge; returns #1 after the edge that sampled the request.
  task automatic do_push(input logic [4:0] rd, input logic [31:0] d, output bit acc);
    in_valid = 1'b1;
    in_rd    = rd;
    in_data  = d;
    #1;
    acc = in_ready;
    if (acc && rd != 5'd0) sb.push_back('{rd: rd, data: d});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clk);
    #1;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout: %0d writebacks outstanding, required 0", sb.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    in_valid = 1'b0;
    wr_stall = 1'b0;
    query_rs = 5'd0;
    query_rt = 5'd3;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    #1;
    vectors += 6;
    if (W_en !== 1'b0) begin miscompares++; $display("FAIL rst_w_en: got %b required 0", W_en); end
    if (count !== 4'd0) begin miscompares++; $display("FAIL rst_count: got %0d required 0", count); end
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready: got %b required 1", in_ready); end
    if (rs_hit !== 1'b0) begin miscompares++; $display("FAIL rst_rs_hit: got %b required 0", rs_hit); end
    if (rt_hit !== 1'b0) begin miscompares++; $display("FAIL rst_rt_hit: got %b required 0", rt_hit); end
    if ({W_write_rd, W_write_data} !== 37'd0) begin
      miscompares++;
      $display("FAIL rst_w_out: got rd=%0d data=%h required 0", W_write_rd, W_write_data);
    end
  endtask

  task automatic test_single();
    bit acc;
    sync();
    wr_stall = 1'b0;
    query_rs = 5'd5;
    do_push(5'd5, 32'h1234_1234, acc);
    #1;
    vectors += 4;
    if (acc !== 1'b1) begin miscompares++; $display("FAIL single_acc: got %b required 1", acc); end
    if (W_en !== 1'b0) begin miscompares++; $display("FAIL single_early: W_en got %b required 0", W_en); end
    if (count !== 4'd1) begin miscompares++; $display("FAIL single_count: got %0d required 1", count); end
    if ({rs_hit, rs_data} !== {1'b1, 32'h1234_1234}) begin
      miscompares++; $display("FAIL single_fwd_q: got hit=%b data=%h required 1/12341234", rs_hit, rs_data);
    end
    sync();
    vectors += 3;
    if ({W_en, W_write_rd} !== {1'b1, 5'd5}) begin
      miscompares++; $display("FAIL single_wb: got en=%b rd=%0d required 1/5", W_en, W_write_rd);
    end
    if ({rs_hit, rs_data} !== {1'b1, 32'h1234_1234}) begin
      miscompares++; $display("FAIL single_fwd_out: got hit=%b data=%h required 1/12341234", rs_hit, rs_data);
    end
    if (count !== 4'd0) begin miscompares++; $display("FAIL single_count2: got %0d required 0", count); end
    sync();
    vectors += 2;
    if ({W_en, W_write_rd} !== {1'b0, 5'd5}) begin
      miscompares++; $display("FAIL single_after: got en=%b rd=%0d required 0/5 (held)", W_en, W_write_rd);
    end
    if (rs_hit !== 1'b0) begin miscompares++; $display("FAIL single_fwd_end: got %b required 0", rs_hit); end
    wait_drain();
  endtask

  task automatic test_full_stall();
    bit acc;
    sync();
    wr_stall = 1'b1;
    query_rs = 5'd3;
    for (int i = 1; i <= 5; i++) begin
      do_push(5'(i), 32'hC0DE_0000 | 32'(i), acc);
      vectors++;
      if (acc !== (i <= 4)) begin
        miscompares++; $display("FAIL full_acc%0d: got %b required %b", i, acc, (i <= 4));
      end
    end
    #1;
    vectors += 3;
    if (count !== 4'd4) begin miscompares++; $display("FAIL full_count: got %0d required 4", count); end
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL full_ready: got %b required 0", in_ready); end
    if ({rs_hit, rs_data} !== {1'b1, 32'hC0DE_0003}) begin
      miscompares++; $display("FAIL full_fwd: got hit=%b data=%h required 1/c0de0003", rs_hit, rs_data);
    end
    wr_stall = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      sync();
      vectors++;
      if ({W_en, W_write_rd} !== {1'b1, 5'(i)}) begin
        miscompares++; $display("FAIL full_drain%0d: got en=%b rd=%0d required 1/%0d", i, W_en, W_write_rd, i);
      end
    end
    do_push(5'd5, 32'hC0DE_0005, acc);
    vectors++;
    if (acc !== 1'b1) begin miscompares++; $display("FAIL full_retry: got %b required 1", acc); end
    wait_drain();
  endtask

  task automatic test_youngest();
    bit acc;
    sync();
    wr_stall = 1'b1;
    do_push(5'd7, 32'hA, acc);
    do_push(5'd7, 32'hB, acc);
    query_rt = 5'd7;
    query_rs = 5'd7;
    #1;
    vectors += 2;
    if ({rt_hit, rt_data} !== {1'b1, 32'hB}) begin
      miscompares++; $display("FAIL young_rt: got hit=%b data=%h required 1/0000000b", rt_hit, rt_data);
    end
    if ({rs_hit, rs_data} !== {1'b1, 32'hB}) begin
      miscompares++; $display("FAIL young_rs: got hit=%b data=%h required 1/0000000b", rs_hit, rs_data);
    end
    wr_stall = 1'b0;
    sync();
    vectors += 2;
    if ({W_en, W_write_data} !== {1'b1, 32'hA}) begin
      miscompares++; $display("FAIL young_wb: got en=%b data=%h required 1/0000000a", W_en, W_write_data);
    end
    if ({rt_hit, rt_data} !== {1'b1, 32'hB}) begin
      miscompares++; $display("FAIL young_over_out: got hit=%b data=%h required 1/0000000b", rt_hit, rt_data);
    end
    wait_drain();
  endtask

  task automatic test_zero();
    bit acc;
    sync();
    wr_stall = 1'b0;
    query_rs = 5'd0;
    do_push(5'd0, 32'hFFFF_FFFF, acc);
    #1;
    vectors += 3;
    if (acc !== 1'b1) begin miscompares++; $display("FAIL zero_acc: got %b required 1", acc); end
    if (count !== 4'd0) begin miscompares++; $display("FAIL zero_count: got %0d required 0", count); end
    if (rs_hit !== 1'b0) begin miscompares++; $display("FAIL zero_fwd: got %b required 0", rs_hit); end
    for (int i = 0; i < 3; i++) begin
      sync();
      vectors++;
      if (W_en !== 1'b0) begin miscompares++; $display("FAIL zero_w_en%0d: got %b required 0", i, W_en); end
    end
  endtask

  task automatic test_back_to_back();
    bit acc;
    logic hit_e;
    logic [31:0] d_e;
    logic [4:0] rd_r;
    sync();
    for (int c = 0; c < 300; c++) begin
      query_rs = 5'($urandom_range(0, 7));
      query_rt = 5'($urandom_range(0, 7));
      #1;
      model_fwd(query_rs, hit_e, d_e);
      vectors++;
      if ({rs_hit, rs_data} !== {hit_e, d_e}) begin
        miscompares++; $display("FAIL b2b_rs c%0d: got hit=%b data=%h required %b/%h", c, rs_hit, rs_data, hit_e, d_e);
      end
      model_fwd(query_rt, hit_e, d_e);
      vectors++;
      if ({rt_hit, rt_data} !== {hit_e, d_e}) begin
        miscompares++; $display("FAIL b2b_rt c%0d: got hit=%b data=%h required %b/%h", c, rt_hit, rt_data, hit_e, d_e);
      end
      wr_stall = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) begin
        rd_r = 5'($urandom_range(0, 7));
        do_push(rd_r, $urandom, acc);
      end else begin
        sync();
      end
    end
    wr_stall = 1'b0;
    in_valid = 1'b0;
    wait_drain();
  endtask

  task automatic test_reset_mid_drain();
    bit acc;
    sync();
    wr_stall = 1'b1;
    do_push(5'd9,  32'h9, acc);
    do_push(5'd10, 32'h10, acc);
    do_push(5'd11, 32'h11, acc);
    wr_stall = 1'b0;
    sync();
    vectors++;
    if ({W_en, W_write_rd} !== {1'b1, 5'd9}) begin
      miscompares++; $display("FAIL mid_first: got en=%b rd=%0d required 1/9", W_en, W_write_rd);
    end
    rst = 1'b0;
    sync();
    rst = 1'b1;
    sb.delete();
    query_rs = 5'd10;
    #1;
    vectors += 4;
    if (W_en !== 1'b0) begin miscompares++; $display("FAIL mid_w_en: got %b required 0", W_en); end
    if (count !== 4'd0) begin miscompares++; $display("FAIL mid_count: got %0d required 0", count); end
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL mid_ready: got %b required 1", in_ready); end
    if (rs_hit !== 1'b0) begin miscompares++; $display("FAIL mid_fwd: got %b required 0", rs_hit); end
    for (int i = 0; i < 4; i++) begin
      sync();
      vectors++;
      if (W_en !== 1'b0) begin miscompares++; $display("FAIL mid_quiet%0d: got %b required 0", i, W_en); end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst      = 1'b0;
    in_valid = 1'b0;
    in_rd    = '0;
    in_data  = '0;
    wr_stall = 1'b0;
    query_rs = '0;
    query_rt = '0;
    test_reset();
    test_single();
    test_full_stall();
    test_youngest();
    test_zero();
    test_back_to_back();
    test_reset_mid_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
